// File: rtl/xcvr_link_supervisor_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : xcvr_link_supervisor_if
// Purpose  : Lane status inputs and bring-up control outputs of the supervisor.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface xcvr_link_supervisor_if #(
  parameter int BYTES = 8
);
  logic             Link_Enable;
  logic             Rx_Ready;
  logic             Rx_Val;
  logic [BYTES-1:0] Rx_Code_Violation;
  logic [BYTES-1:0] Rx_Disparity_Error;
  logic             Sync_OK;
  logic             Pcs_Rst_N;
  logic             Sync_Req;
  logic             Link_Up;
  logic             Link_Fail;
  logic [15:0]      Err_Count;
  logic [3:0]       Retry_Count;
  logic [2:0]       State;

  modport master (
    input  Link_Enable, Rx_Ready, Rx_Val, Rx_Code_Violation, Rx_Disparity_Error, Sync_OK,
    output Pcs_Rst_N, Sync_Req, Link_Up, Link_Fail, Err_Count, Retry_Count, State
  );

  modport slave (
    output Link_Enable, Rx_Ready, Rx_Val, Rx_Code_Violation, Rx_Disparity_Error, Sync_OK,
    input  Pcs_Rst_N, Sync_Req, Link_Up, Link_Fail, Err_Count, Retry_Count, State
  );
endinterface
`default_nettype wire

// File: rtl/xcvr_link_supervisor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : xcvr_link_supervisor
// Purpose  : RX lane bring-up/recovery FSM with windowed error accounting.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module xcvr_link_supervisor #(
  parameter int BYTES          = 8,
  parameter int PCS_RST_CYCLES = 32,
  parameter int SYNC_TIMEOUT   = 65535,
  parameter int STABLE_CYCLES  = 256,
  parameter int ERR_WINDOW     = 1024,
  parameter int ERR_THRESH     = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  wire                    Clock,
  input  wire                    Reset_N,
  xcvr_link_supervisor_if.master bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PCS_RESET  = 3'd1;
  localparam logic [2:0] S_WAIT_READY = 3'd2;
  localparam logic [2:0] S_REQ_SYNC   = 3'd3;
  localparam logic [2:0] S_WAIT_SYNC  = 3'd4;
  localparam logic [2:0] S_STABLE     = 3'd5;
  localparam logic [2:0] S_LINK_UP    = 3'd6;
  localparam logic [2:0] S_FAILED     = 3'd7;

  localparam int CNT_MAX = (SYNC_TIMEOUT > STABLE_CYCLES)
                         ? ((SYNC_TIMEOUT > PCS_RST_CYCLES) ? SYNC_TIMEOUT : PCS_RST_CYCLES)
                         : ((STABLE_CYCLES > PCS_RST_CYCLES) ? STABLE_CYCLES : PCS_RST_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int E_W     = $clog2(BYTES + 1);
  localparam int ACC_W   = $clog2(ERR_WINDOW * BYTES + 1);
  localparam int WIN_W   = $clog2(ERR_WINDOW + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [15:0]      err_count_q, err_count_d;
  logic [3:0]       retry_q, retry_d;
  logic             pcs_rst_n_q, pcs_rst_n_d;
  logic             sync_req_q, sync_req_d;
  logic             link_up_q, link_up_d;
  logic             link_fail_q, link_fail_d;

  logic [BYTES-1:0] flagged;
  logic [E_W-1:0]   err_bytes;
  logic [ACC_W-1:0] acc_sum;
  logic [16:0]      err_sum;
  logic             active, err_event, retry_take, lane_lost;

  // Error event looks at the accumulator plus this cycle's flagged bytes.
  always_comb begin : p_err
    flagged   = bus.Rx_Code_Violation | bus.Rx_Disparity_Error;
    err_bytes = '0;
    for (int i = 0; i < BYTES; i++) begin
      err_bytes = err_bytes + E_W'(flagged[i]);
    end
    if (!bus.Rx_Val) begin
      err_bytes = '0;
    end
    active    = (state_q == S_STABLE) || (state_q == S_LINK_UP);
    acc_sum   = acc_q + ACC_W'(err_bytes);
    err_event = active && (int'(acc_sum) >= ERR_THRESH);
    lane_lost = !bus.Sync_OK || !bus.Rx_Ready || err_event;
  end

  always_ff @(posedge Clock or negedge Reset_N) begin : p_state_reg
    if (!Reset_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : p_next
    state_d    = state_q;
    retry_take = 1'b0;
    case (state_q)
      S_IDLE:       state_d = S_PCS_RESET;
      S_PCS_RESET:  if (cnt_q == CNT_W'(PCS_RST_CYCLES - 1)) state_d = S_WAIT_READY;
      S_WAIT_READY: begin
        if (bus.Rx_Ready && bus.Rx_Val)               state_d    = S_REQ_SYNC;
        else if (cnt_q == CNT_W'(SYNC_TIMEOUT - 1))   retry_take = 1'b1;
      end
      S_REQ_SYNC:   state_d = S_WAIT_SYNC;
      S_WAIT_SYNC: begin
        if (bus.Sync_OK)                              state_d    = S_STABLE;
        else if (cnt_q == CNT_W'(SYNC_TIMEOUT - 1))   retry_take = 1'b1;
      end
      S_STABLE: begin
        if (lane_lost)                                retry_take = 1'b1;
        else if (cnt_q == CNT_W'(STABLE_CYCLES - 1))  state_d    = S_LINK_UP;
      end
      S_LINK_UP:    if (lane_lost) retry_take = 1'b1;
      S_FAILED:     state_d = S_FAILED;
      default:      state_d = S_IDLE;
    endcase
    if (retry_take) begin
      state_d = (retry_q == 4'(MAX_RETRIES)) ? S_FAILED : S_PCS_RESET;
    end
    if (!bus.Link_Enable) begin
      state_d = S_IDLE;
    end
  end

  // Outputs are registered from the next state so they line up with State.
  always_comb begin : p_out
    pcs_rst_n_d = !((state_d == S_IDLE) || (state_d == S_PCS_RESET) || (state_d == S_FAILED));
    sync_req_d  = (state_d == S_REQ_SYNC);
    link_up_d   = (state_d == S_LINK_UP);
    link_fail_d = (state_d == S_FAILED);

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_PCS_RESET) || (state_q == S_WAIT_READY) ||
                 (state_q == S_WAIT_SYNC) || (state_q == S_STABLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    retry_d = retry_q;
    if ((state_q == S_IDLE) && (state_d == S_PCS_RESET)) begin
      retry_d = '0;
    end else if ((state_d == S_LINK_UP) && (state_q != S_LINK_UP)) begin
      retry_d = '0;
    end else if (retry_take && (state_d == S_PCS_RESET)) begin
      retry_d = retry_q + 4'd1;
    end

    err_sum     = {1'b0, err_count_q} + 17'(err_bytes);
    err_count_d = err_count_q;
    if ((state_q == S_IDLE) && (state_d == S_PCS_RESET)) begin
      err_count_d = '0;
    end else if (active) begin
      err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    acc_d = '0;
    win_d = '0;
    if (active && (win_q != WIN_W'(ERR_WINDOW - 1))) begin
      acc_d = acc_sum;
      win_d = win_q + WIN_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset_N) begin : p_data_reg
    if (!Reset_N) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      win_q       <= '0;
      err_count_q <= '0;
      retry_q     <= '0;
      pcs_rst_n_q <= 1'b0;
      sync_req_q  <= 1'b0;
      link_up_q   <= 1'b0;
      link_fail_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      win_q       <= win_d;
      err_count_q <= err_count_d;
      retry_q     <= retry_d;
      pcs_rst_n_q <= pcs_rst_n_d;
      sync_req_q  <= sync_req_d;
      link_up_q   <= link_up_d;
      link_fail_q <= link_fail_d;
    end
  end

  assign bus.Pcs_Rst_N   = pcs_rst_n_q;
  assign bus.Sync_Req    = sync_req_q;
  assign bus.Link_Up     = link_up_q;
  assign bus.Link_Fail   = link_fail_q;
  assign bus.Err_Count   = err_count_q;
  assign bus.Retry_Count = retry_q;
  assign bus.State       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_xcvr_link_supervisor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_xcvr_link_supervisor
// Purpose  : Directed plus randomized checks of the link supervisor.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_xcvr_link_supervisor;

  localparam int BYTES   = 8;
  localparam int PCS_RST = 4;
  localparam int SYNC_TO = 32;
  localparam int STABLE  = 8;
  localparam int WIN     = 16;
  localparam int THRESH  = 4;
  localparam int MAXR    = 2;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic sat_en = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   hist[$];
  int   exp_err = 0;

  always #5 clk = ~clk;

  xcvr_link_supervisor_if #(.BYTES(BYTES)) bus  ();
  xcvr_link_supervisor_if #(.BYTES(BYTES)) sbus ();

  assign sbus.Link_Enable        = sat_en;
  assign sbus.Rx_Ready           = bus.Rx_Ready;
  assign sbus.Rx_Val             = bus.Rx_Val;
  assign sbus.Rx_Code_Violation  = bus.Rx_Code_Violation;
  assign sbus.Rx_Disparity_Error = bus.Rx_Disparity_Error;
  assign sbus.Sync_OK            = bus.Sync_OK;

  xcvr_link_supervisor #(
    .BYTES(BYTES), .PCS_RST_CYCLES(PCS_RST), .SYNC_TIMEOUT(SYNC_TO), .STABLE_CYCLES(STABLE),
    .ERR_WINDOW(WIN), .ERR_THRESH(THRESH), .MAX_RETRIES(MAXR)
  ) u_dut (.Clock(clk), .Reset_N(rst_n), .bus(bus));

  xcvr_link_supervisor #(
    .BYTES(BYTES), .PCS_RST_CYCLES(PCS_RST), .SYNC_TIMEOUT(SYNC_TO), .STABLE_CYCLES(STABLE),
    .ERR_WINDOW(WIN), .ERR_THRESH(65535), .MAX_RETRIES(MAXR)
  ) u_sat (.Clock(clk), .Reset_N(rst_n), .bus(sbus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [BYTES-1:0] v);
    int c = 0;
    for (int i = 0; i < BYTES; i++) c += int'(v[i]);
    return c;
  endfunction

  // One cycle in STABLE_CHECK/LINK_UP; event = window-so-far sum of flagged bytes.
  task automatic active_cycle(input logic [7:0] cv, input logic [7:0] de, input logic val,
                              output bit ev);
    int e, idx, start, sum;
    bus.Rx_Code_Violation  = cv;
    bus.Rx_Disparity_Error = de;
    bus.Rx_Val             = val;
    e = val ? popc(cv | de) : 0;
    hist.push_back(e);
    idx   = hist.size() - 1;
    start = idx - (idx % WIN);
    sum   = 0;
    for (int j = start; j <= idx; j++) sum += hist[j];
    ev      = (sum >= THRESH);
    exp_err = (exp_err + e > 65535) ? 65535 : exp_err + e;
    tick();
    chk("err_count", bus.Err_Count, exp_err);
  endtask

  task automatic lu_cycle(input logic [7:0] cv, input logic [7:0] de, input logic val,
                          output bit ev);
    active_cycle(cv, de, val, ev);
    chk("lu_link_up", bus.Link_Up, !ev);
    chk("lu_state", bus.State, ev ? 3'd1 : 3'd6);
    chk("lu_retry", bus.Retry_Count, ev ? 4'd1 : 4'd0);
  endtask

  task automatic wait_req(output int pcs_low);
    int n = 0;
    bus.Rx_Ready = 1'b1; bus.Rx_Val = 1'b1; bus.Sync_OK = 1'b0;
    bus.Rx_Code_Violation = '0; bus.Rx_Disparity_Error = '0;
    pcs_low = 0;
    while (bus.Sync_Req !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (bus.State === 3'd1 && bus.Pcs_Rst_N === 1'b0) pcs_low++;
    end
    chk("sync_req_seen", bus.Sync_Req, 1'b1);
    chk("req_state", bus.State, 3'd3);
  endtask

  task automatic bring_up(output int pcs_low);
    bit ev;
    wait_req(pcs_low);
    repeat (2) begin
      tick();
      chk("sync_req_width", bus.Sync_Req, 1'b0);
    end
    bus.Sync_OK = 1'b1;
    tick();
    chk("stable_entry", bus.State, 3'd5);
    hist.delete();
    for (int i = 0; i < STABLE; i++) begin
      active_cycle(8'h00, 8'h00, 1'b1, ev);
      chk("link_up_timing", bus.Link_Up, (i == STABLE - 1));
    end
    chk("up_state", bus.State, 3'd6);
    chk("up_retry", bus.Retry_Count, 4'd0);
    chk("up_pcs", bus.Pcs_Rst_N, 1'b1);
  endtask

  initial begin
    bit ev;
    int pl, n, exp_sat;
    int p_cyc[$];
    int p_ret[$];

    bus.Link_Enable = 1'b0; bus.Rx_Ready = 1'b0; bus.Rx_Val = 1'b0; bus.Sync_OK = 1'b0;
    bus.Rx_Code_Violation = '0; bus.Rx_Disparity_Error = '0;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_state", bus.State, 3'd0);
    chk("rst_pcs", bus.Pcs_Rst_N, 1'b0);
    chk("rst_sync_req", bus.Sync_Req, 1'b0);
    chk("rst_link_up", bus.Link_Up, 1'b0);
    chk("rst_link_fail", bus.Link_Fail, 1'b0);
    chk("rst_err", bus.Err_Count, 16'd0);
    chk("rst_retry", bus.Retry_Count, 4'd0);
    rst_n = 1'b1;
    tick();

    // Clean bring-up
    bus.Link_Enable = 1'b1;
    exp_err = 0;
    bring_up(pl);
    chk("pcs_low_cycles", pl, PCS_RST);

    // Two 8'h03 cycles cross the threshold on the second one
    lu_cycle(8'h03, 8'h00, 1'b1, ev);
    lu_cycle(8'h00, 8'h03, 1'b1, ev);
    chk("thr_err_count", bus.Err_Count, 16'd4);
    chk("thr_pcs", bus.Pcs_Rst_N, 1'b0);

    bus.Link_Enable = 1'b0;
    tick();
    chk("dis_state", bus.State, 3'd0);
    bus.Link_Enable = 1'b1;
    exp_err = 0;
    bring_up(pl);
    chk("reup_err", bus.Err_Count, 16'd0);

    // Window wrap: 1+2 in window 0 (2 on its wrap cycle), 3 in window 1
    repeat (5) lu_cycle(8'h00, 8'h00, 1'b1, ev);
    lu_cycle(8'h10, 8'h00, 1'b1, ev);
    lu_cycle(8'h00, 8'h00, 1'b1, ev);
    lu_cycle(8'h01, 8'h02, 1'b1, ev);
    lu_cycle(8'h00, 8'h07, 1'b1, ev);
    chk("wrap_err", bus.Err_Count, 16'd6);
    chk("wrap_link_up", bus.Link_Up, 1'b1);
    for (int k = 17; k < 31; k++) lu_cycle(8'($urandom), 8'($urandom), 1'b0, ev);
    lu_cycle(8'h80, 8'h00, 1'b1, ev);
    chk("wrap_event_err", bus.Err_Count, 16'd7);

    // Random traffic in LINK_UP against the window model
    bring_up(pl);
    for (int i = 0; i < 80; i++) begin
      lu_cycle(($urandom_range(0, 3) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00,
               ($urandom_range(0, 3) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00,
               1'($urandom_range(0, 3) != 0), ev);
      if (ev) break;
    end

    // Sync timeout exhausts the retry budget
    bus.Rx_Code_Violation = '0; bus.Rx_Disparity_Error = '0;
    bus.Link_Enable = 1'b0;
    tick();
    chk("to_idle", bus.State, 3'd0);
    bus.Link_Enable = 1'b1; bus.Sync_OK = 1'b0; bus.Rx_Ready = 1'b1; bus.Rx_Val = 1'b1;
    n = 0;
    while (bus.State !== 3'd7 && n < 400) begin
      tick();
      n++;
      if (bus.Sync_Req === 1'b1) begin
        p_cyc.push_back(n);
        p_ret.push_back(int'(bus.Retry_Count));
      end
    end
    chk("to_pulses", p_cyc.size(), MAXR + 1);
    for (int i = 0; i < p_ret.size() && i <= MAXR; i++) chk("to_retry_seq", p_ret[i], i);
    if (p_cyc.size() >= 2) chk("to_spacing", p_cyc[1] - p_cyc[0], 1 + SYNC_TO + PCS_RST + 1);
    if (p_cyc.size() >= 1) chk("to_fail_latency", n - p_cyc[p_cyc.size() - 1], 1 + SYNC_TO);
    chk("to_state", bus.State, 3'd7);
    chk("to_link_fail", bus.Link_Fail, 1'b1);
    chk("to_pcs", bus.Pcs_Rst_N, 1'b0);
    repeat (3) tick();
    chk("to_hold", bus.State, 3'd7);
    bus.Link_Enable = 1'b0;
    tick();
    chk("fail_exit_state", bus.State, 3'd0);
    chk("fail_exit_flag", bus.Link_Fail, 1'b0);

    // Asynchronous reset while LINK_UP
    bus.Link_Enable = 1'b1;
    exp_err = 0;
    bring_up(pl);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", bus.State, 3'd0);
    chk("arst_link_up", bus.Link_Up, 1'b0);
    chk("arst_pcs", bus.Pcs_Rst_N, 1'b0);
    chk("arst_err", bus.Err_Count, 16'd0);
    chk("arst_retry", bus.Retry_Count, 4'd0);
    chk("arst_sync_req", bus.Sync_Req, 1'b0);
    chk("arst_link_fail", bus.Link_Fail, 1'b0);
    #2 rst_n = 1'b1;

    // Link_Enable drop while in WAIT_SYNC
    wait_req(pl);
    tick();
    chk("ws_state", bus.State, 3'd4);
    bus.Link_Enable = 1'b0;
    tick();
    chk("ws_drop_state", bus.State, 3'd0);
    chk("ws_drop_pcs", bus.Pcs_Rst_N, 1'b0);

    // Saturation on the high-threshold instance
    bus.Link_Enable = 1'b1;
    sat_en = 1'b1;
    exp_err = 0;
    bring_up(pl);
    chk("sat_up", sbus.Link_Up, 1'b1);
    bus.Rx_Code_Violation = 8'hFF; bus.Rx_Val = 1'b1;
    exp_sat = 0;
    for (int i = 0; i < 8200; i++) begin
      tick();
      exp_sat = (exp_sat + BYTES > 65535) ? 65535 : exp_sat + BYTES;
      chk("sat_err", sbus.Err_Count, exp_sat);
    end
    chk("sat_final", sbus.Err_Count, 16'hFFFF);
    chk("sat_link_up", sbus.Link_Up, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xcvr_link_supervisor.md
Name: xcvr_link_supervisor

Overview:
- Bring-up and recovery controller for one transceiver RX lane (8 bytes per word, 8b10b).
- Drives the lane PCS/PMA reset and the Sync_Req input of the SYNC handler.
- Watches RX ready/valid, code-violation and disparity-error flags and SYNC_OK.
- Declares link up, counts errors, retries bring-up on failure, and latches a fail flag after retries are exhausted. Runs in the lane RX clock domain.

Parameters:
- BYTES, 8: bytes per RX word (width of the error flag vectors).
- PCS_RST_CYCLES, 32: cycles Pcs_Rst_N is held low per reset attempt.
- SYNC_TIMEOUT, 65535: cycle limit in each of WAIT_READY and WAIT_SYNC.
- STABLE_CYCLES, 256: error-free cycles with Sync_OK high needed before Link_Up.
- ERR_WINDOW, 1024: length of the error-accounting window in cycles.
- ERR_THRESH, 16: flagged bytes within one window that trigger an error event.
- MAX_RETRIES, 3: retry budget before FAILED (Retry_Count is 4 bits, so MAX_RETRIES ≤ 15).

Ports:
- Clock  in  1  lane RX clock.
- Reset_N  in  1  asynchronous active-low reset.
- Link_Enable  in  1  level; 1 = bring the link up and keep it up.
- Rx_Ready  in  1  lane RX_READY.
- Rx_Val  in  1  lane RX_VAL.
- Rx_Code_Violation  in  BYTES  per-byte code violation flags.
- Rx_Disparity_Error  in  BYTES  per-byte disparity error flags.
- Sync_OK  in  1  from the SYNC handler.
- Pcs_Rst_N  out  1  active-low reset to lane PCS/PMA.
- Sync_Req  out  1  one-cycle sync request pulse.
- Link_Up  out  1  link up and healthy.
- Link_Fail  out  1  retry budget exhausted.
- Err_Count  out  16  saturating count of flagged bytes.
- Retry_Count  out  4  retries used in the current attempt.
- State  out  3  current state encoding.

Behaviour:
- All outputs are registered. Reset values: Pcs_Rst_N=0, Sync_Req=0, Link_Up=0, Link_Fail=0, Err_Count=0, Retry_Count=0, State=0 (IDLE).
- State encoding: IDLE=0, PCS_RESET=1, WAIT_READY=2, REQ_SYNC=3, WAIT_SYNC=4, STABLE_CHECK=5, LINK_UP=6, FAILED=7.
- Highest priority: Link_Enable=0 in any state → IDLE on the next edge.
- IDLE: Pcs_Rst_N=0. Link_Enable=1 → PCS_RESET; Err_Count and Retry_Count cleared on this transition.
- PCS_RESET: Pcs_Rst_N=0 for exactly PCS_RST_CYCLES cycles, then → WAIT_READY. Pcs_Rst_N=1 in every state except IDLE, PCS_RESET and FAILED.
- WAIT_READY: Rx_Ready=1 and Rx_Val=1 in the same cycle → REQ_SYNC. Timeout counter reaching SYNC_TIMEOUT → RETRY.
- REQ_SYNC: Sync_Req=1 for exactly this one cycle → WAIT_SYNC.
- WAIT_SYNC: Sync_OK=1 → STABLE_CHECK. Timeout → RETRY.
- STABLE_CHECK: the error window and the stable counter restart on entry. The counter counts only cycles with Sync_OK=1, Rx_Ready=1 and no error event.
  - Counter reaches STABLE_CYCLES → LINK_UP.
  - Sync_OK=0, Rx_Ready=0 or an error event → RETRY.
- LINK_UP: Link_Up=1 and Retry_Count is cleared on entry (fresh budget). Sync_OK=0, Rx_Ready=0 or an error event → RETRY, and Link_Up drops on the same edge.
- RETRY is a transition decision, not a state:
  - If Retry_Count==MAX_RETRIES → FAILED.
  - Otherwise Retry_Count increments and the FSM goes to PCS_RESET.
- FAILED: Link_Fail=1 and Pcs_Rst_N=0. Exits only through Link_Enable=0 → IDLE, which clears Link_Fail.
- Error accounting, active only in STABLE_CHECK and LINK_UP:
  - Per-cycle error count: e = popcount(Rx_Code_Violation | Rx_Disparity_Error), counted only when Rx_Val=1. Range 0..8, using a 4-bit adder tree.
  - A window accumulator adds e each cycle. Error event = (acc + e ≥ ERR_THRESH), evaluated on the same cycle's data.
  - The window counter wraps at ERR_WINDOW-1. On the wrap cycle the event check still includes the current e, then the accumulator is cleared.
  - Err_Count += e, saturating at 16'hFFFF.
- Timeout and cycle counters reset on every state entry.
- Reset_N asserted mid-operation returns everything to reset values immediately (asynchronously).

Test Plan:
Bench parameters: PCS_RST_CYCLES=4, SYNC_TIMEOUT=32, STABLE_CYCLES=8, ERR_WINDOW=16, ERR_THRESH=4, MAX_RETRIES=2.
- Clean bring-up: Link_Enable=1, Rx_Ready/Rx_Val high, Sync_OK rises 3 cycles after Sync_Req → Pcs_Rst_N low 4 cycles, exactly one Sync_Req pulse, Link_Up=1 after 8 stable cycles, Retry_Count=0.
- Sync timeout: Sync_OK held 0 → 3 Sync_Req pulses (Retry_Count 0,1,2), then State=7, Link_Fail=1, Pcs_Rst_N=0. Dropping Link_Enable → State=0, Link_Fail=0.
- Error threshold in LINK_UP: inject flag vectors 8'h03 then 8'h03 in one window → event on the 2nd cycle, Link_Up=0, Retry_Count=1, State=1, Err_Count=4.
- Window wrap: 3 flagged bytes in window 1, 3 in window 2 → no event, Link_Up stays 1, Err_Count=6. Errors on the wrap cycle itself are counted before the clear.
- Saturation and gating: force 8'hFF continuously with ERR_THRESH=65535 → Err_Count stops at 16'hFFFF. Errors with Rx_Val=0 are ignored.
- Async reset while in LINK_UP and Link_Enable drop while in WAIT_SYNC → all outputs at reset values immediately, or State=0 on the next edge, respectively.
